// File: rtl/reg_siso_pkg.sv
// Shared constants for the reg_siso serial-in/serial-out shift register.
// Direction encodings and the legal range for the length parameter N.
package reg_siso_pkg;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  localparam int N_MIN = 2;
  localparam int N_MAX = 32;

endpackage

// File: rtl/reg_siso_cell.sv
// One bit of the shift register: enabled flop with synchronous active-low clear.
// Next value comes from the higher neighbour on a right shift, the lower one on a left shift.
module reg_siso_cell
  import reg_siso_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic dir_i,
  input  logic hi_i,
  input  logic lo_i,
  output logic q_o
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = (dir_i == DIR_RIGHT) ? hi_i : lo_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_siso.sv
// N-bit bidirectional serial-in/serial-out shift register; Q is combinational from r and dir.
// Optional parallel view of the register on Qpar when REG_SISO_PAR_OUT_EN is defined.
module reg_siso
  import reg_siso_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         dir,
  input  logic         D,
  output logic         Q
`ifdef REG_SISO_PAR_OUT_EN
  ,
  output logic [N-1:0] Qpar
`endif
);

  if ((N < N_MIN) || (N > N_MAX)) begin : g_bad_n
    $error("reg_siso: N=%0d outside legal range %0d..%0d", N, N_MIN, N_MAX);
  end

  logic [N-1:0] r_q;

  // End cells take D in place of the missing neighbour.
  for (genvar i = 0; i < N; i++) begin : g_cell
    logic hi;
    logic lo;

    if (i == N - 1) begin : g_hi_d
      assign hi = D;
    end else begin : g_hi_r
      assign hi = r_q[i+1];
    end

    if (i == 0) begin : g_lo_d
      assign lo = D;
    end else begin : g_lo_r
      assign lo = r_q[i-1];
    end

    reg_siso_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .en_i  (enable),
      .dir_i (dir),
      .hi_i  (hi),
      .lo_i  (lo),
      .q_o   (r_q[i])
    );
  end

  assign Q = (dir == DIR_RIGHT) ? r_q[0] : r_q[N-1];

`ifdef REG_SISO_PAR_OUT_EN
  assign Qpar = r_q;
`endif

endmodule

// File: tb/tb_reg_siso.sv
// Directed bench for reg_siso (N=4): vector table plus hand sequences for dir flips,
// inter-edge glitches and a left/right instance pair fed identical data.
module tb_reg_siso;

  localparam int N = 4;

  logic clk;
  logic rst;
  logic enable;
  logic dir;
  logic D;
  logic Q;
  logic Q_l;
`ifdef REG_SISO_PAR_OUT_EN
  logic [N-1:0] qpar;
  logic [N-1:0] qpar_l;
`endif

  int n_vec = 0;
  int n_err = 0;

  reg_siso #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .dir    (dir),
    .D      (D),
    .Q      (Q)
`ifdef REG_SISO_PAR_OUT_EN
    ,
    .Qpar   (qpar)
`endif
  );

  reg_siso #(.N(N)) dut_l (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .dir    (1'b0),
    .D      (D),
    .Q      (Q_l)
`ifdef REG_SISO_PAR_OUT_EN
    ,
    .Qpar   (qpar_l)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        dir;
    logic        d;
    logic [3:0]  exp_r;
    logic        exp_q;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rs, input logic en, input logic dr, input logic d,
                     input logic [3:0] er, input logic eq, input string nm);
    vec_t v;
    v.rst = rs; v.en = en; v.dir = dr; v.d = d;
    v.exp_r = er; v.exp_q = eq; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, then sample 1 ns after the rising edge.
  task automatic apply(input logic rs, input logic en, input logic dr, input logic d);
    @(negedge clk);
    rst = rs; enable = en; dir = dr; D = d;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] hist;
  logic [7:0] pat;

  initial begin
    rst = 1'b1; enable = 1'b0; dir = 1'b1; D = 1'b0;

    // reset overriding enable/D, observed on both dir values
    add(0, 1, 1, 1, 4'b0000, 0, "rst_dirR");
    add(0, 1, 0, 1, 4'b0000, 0, "rst_dirL");
    // right shift of ones
    add(1, 1, 1, 1, 4'b1000, 0, "shr1");
    add(1, 1, 1, 1, 4'b1100, 0, "shr2");
    add(1, 1, 1, 1, 4'b1110, 0, "shr3");
    add(1, 1, 1, 1, 4'b1111, 1, "shr4");
    add(0, 1, 0, 1, 4'b0000, 0, "rst_mid1");
    // left shift of ones
    add(1, 1, 0, 1, 4'b0001, 0, "shl1");
    add(1, 1, 0, 1, 4'b0011, 0, "shl2");
    add(1, 1, 0, 1, 4'b0111, 0, "shl3");
    add(1, 1, 0, 1, 4'b1111, 1, "shl4");
    add(0, 1, 1, 0, 4'b0000, 0, "rst_mid2");
    // shift in 1,0,1,1 then hold with D toggling
    add(1, 1, 1, 1, 4'b1000, 0, "pat1");
    add(1, 1, 1, 0, 4'b0100, 0, "pat0");
    add(1, 1, 1, 1, 4'b1010, 0, "pat1b");
    add(1, 1, 1, 1, 4'b1101, 1, "pat1c");
    add(1, 0, 1, 0, 4'b1101, 1, "hold0");
    add(1, 0, 1, 1, 4'b1101, 1, "hold1");
    add(1, 0, 1, 0, 4'b1101, 1, "hold2");
    // fill to 1111, reset mid-stream, then immediate shift on release
    add(1, 1, 1, 1, 4'b1110, 0, "fill1");
    add(1, 1, 1, 1, 4'b1111, 1, "fill2");
    add(0, 1, 1, 1, 4'b0000, 0, "rst_full");
    add(1, 1, 1, 1, 4'b1000, 0, "rel_shift");
    // walk the single 1 down to bit 0
    add(1, 1, 1, 0, 4'b0100, 0, "walk1");
    add(1, 1, 1, 0, 4'b0010, 0, "walk2");
    add(1, 1, 1, 0, 4'b0001, 1, "walk3");

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].dir, tbl[i].d);
      check({tbl[i].name, ".r"}, 32'(dut.r_q), 32'(tbl[i].exp_r));
      check({tbl[i].name, ".Q"}, 32'(Q), 32'(tbl[i].exp_q));
`ifdef REG_SISO_PAR_OUT_EN
      check({tbl[i].name, ".Qpar"}, 32'(qpar), 32'(tbl[i].exp_r));
`endif
    end

    // dir flip with enable low: Q follows in the same cycle, r untouched
    enable = 1'b0; dir = 1'b1;
    #1 check("flip.Q_before", 32'(Q), 32'd1);
    dir = 1'b0;
    #1 check("flip.Q_after", 32'(Q), 32'd0);
    check("flip.r_same_cycle", 32'(dut.r_q), 32'b0001);
    apply(1, 0, 0, 1);
    check("flip.r_next_edge", 32'(dut.r_q), 32'b0001);
    check("flip.Q_next_edge", 32'(Q), 32'd0);

    // contents are kept across the flip; shifting continues leftward
    apply(1, 1, 0, 0);
    check("left_after_flip1.r", 32'(dut.r_q), 32'b0010);
    apply(1, 1, 0, 0);
    check("left_after_flip2.r", 32'(dut.r_q), 32'b0100);
    apply(1, 1, 0, 0);
    check("left_after_flip3.r", 32'(dut.r_q), 32'b1000);
    check("left_after_flip3.Q", 32'(Q), 32'd1);
    dir = 1'b1;
    #1 check("flip_back.Q", 32'(Q), 32'd0);

    // pulses between edges must not disturb r
    enable = 1'b1; D = 1'b1; dir = 1'b0;
    #1 D = 1'b0; dir = 1'b1;
    #1 enable = 1'b0; D = 1'b1;
    @(posedge clk);
    #1 check("glitch.r", 32'(dut.r_q), 32'b1000);

    // right and left instances fed the same D give the same Q, delayed N edges
    apply(0, 1, 1, 0);
    check("pair_rst.Q", 32'(Q), 32'd0);
    check("pair_rst.Q_l", 32'(Q_l), 32'd0);
    hist = 4'b0000;
    pat  = 8'b1011_0010;
    for (int k = 7; k >= 0; k--) begin
      apply(1, 1, 1, pat[k]);
      hist = {hist[2:0], pat[k]};
      check($sformatf("pair%0d.Q", 7 - k), 32'(Q), 32'(hist[3]));
      check($sformatf("pair%0d.Q_l", 7 - k), 32'(Q_l), 32'(hist[3]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
